// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 responder in front of a single-port synchronous word SRAM.
// Serves one transaction at a time, either single-beat or INCR/FIXED bursts of up to 256 beats.
// Optional build macro AXI_SLV_STALL_EN enables LFSR-driven pseudo-random stalls.
//
// state   | meaning
// IDLE    | arbitrate AR against AW; prio_read picks the winner when both are valid
// RD_REQ  | issue the SRAM read for the current beat
// RD_CAP  | capture ram_rdata into the read data register
// RD_RESP | present the R beat and hold it until rready
// WR_DATA | accept W beats, each written to the SRAM in its handshake cycle
// WR_RESP | present the B response and hold it until bready
module axi_sram_slave #(
  parameter int ADDR_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP} state_t;

  state_t              state_q, state_d;
  logic                prio_read_q, prio_read_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          len_q, len_d;
  logic [3:0]          id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          burst_q, burst_d;
  logic                err_q, err_d;
  logic                mis_q, mis_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                stall;

  // Address bits outside the word index and the write id carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{araddr[31:ADDR_W+2], araddr[1:0], awaddr[31:ADDR_W+2], awaddr[1:0], wid};

`ifdef AXI_SLV_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4; bit 0 requests a stall cycle.
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register, free running.
  always_ff @(posedge aclk) begin
    if (!aresetn) lfsr_q <= 8'hA5;
    else          lfsr_q <= lfsr_d;
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign rid       = id_q;
  assign bid       = id_q;
  assign rdata     = rdata_q;
  assign rresp     = err_q ? 2'b10 : 2'b00;
  assign bresp     = (err_q | mis_q) ? 2'b10 : 2'b00;
  assign rlast     = (state_q == RD_RESP) && (cnt_q == len_q);
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata;

  // Next-state, datapath updates and handshake/SRAM outputs.
  always_comb begin
    state_d     = state_q;
    prio_read_d = prio_read_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    id_d        = id_q;
    addr_d      = addr_q;
    burst_d     = burst_q;
    err_d       = err_q;
    mis_d       = mis_q;
    rdata_d     = rdata_q;
    arready     = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    rvalid      = 1'b0;
    bvalid      = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 4'b0000;
    case (state_q)
      IDLE: begin
        arready = !stall && (!awvalid || prio_read_q);
        awready = !stall && (!arvalid || !prio_read_q);
        if (arvalid && arready) begin
          id_d        = arid;
          addr_d      = araddr[ADDR_W+1:2];
          len_d       = arlen;
          burst_d     = arburst;
          err_d       = (arsize > 3'b010);
          cnt_d       = 8'd0;
          prio_read_d = 1'b0;
          state_d     = RD_REQ;
        end else if (awvalid && awready) begin
          id_d        = awid;
          addr_d      = awaddr[ADDR_W+1:2];
          len_d       = awlen;
          burst_d     = awburst;
          err_d       = (awsize > 3'b010);
          mis_d       = 1'b0;
          cnt_d       = 8'd0;
          prio_read_d = 1'b1;
          state_d     = WR_DATA;
        end
      end
      RD_REQ: begin
        ram_en  = !err_q;
        state_d = RD_CAP;
      end
      RD_CAP: begin
        rdata_d = err_q ? 32'd0 : ram_rdata;
        if (!stall) state_d = RD_RESP;
      end
      RD_RESP: begin
        rvalid = 1'b1;
        if (rready) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            if (burst_q != 2'b00) addr_d = addr_q + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      WR_DATA: begin
        wready = !stall;
        if (wvalid && wready) begin
          ram_en = 1'b1;
          ram_we = err_q ? 4'b0000 : wstrb;
          cnt_d  = cnt_q + 8'd1;
          if (burst_q != 2'b00) addr_d = addr_q + 1'b1;
          if (wlast) begin
            if (cnt_q != len_q) mis_d = 1'b1;
            state_d = WR_RESP;
          end else if (cnt_q == len_q) begin
            mis_d = 1'b1;
          end
        end
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle must never reach the SRAM, even mid-burst.
    if (!aresetn) begin
      ram_en = 1'b0;
      ram_we = 4'b0000;
    end
  end

  // State and datapath registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      prio_read_q <= 1'b1;
      cnt_q       <= 8'd0;
      len_q       <= 8'd0;
      id_q        <= 4'd0;
      addr_q      <= '0;
      burst_q     <= 2'b00;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      prio_read_q <= prio_read_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural SRAM model.
module tb_axi_sram_slave;
  localparam int ADDR_W = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [3:0] arid; logic [31:0] araddr; logic [7:0] arlen; logic [2:0] arsize; logic [1:0] arburst; logic arvalid; logic arready;
  logic [3:0] rid; logic [31:0] rdata; logic [1:0] rresp; logic rlast, rvalid, rready;
  logic [3:0] awid; logic [31:0] awaddr; logic [7:0] awlen; logic [2:0] awsize; logic [1:0] awburst; logic awvalid, awready;
  logic [3:0] wid; logic [31:0] wdata; logic [3:0] wstrb; logic wlast, wvalid, wready;
  logic [3:0] bid; logic [1:0] bresp; logic bvalid, bready;
  logic ram_en; logic [3:0] ram_we; logic [ADDR_W-1:0] ram_addr; logic [31:0] ram_wdata; logic [31:0] ram_rdata;

  always #5 aclk = ~aclk;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int wr_cnt = 0;
  int en_cnt = 0;

  always @(posedge aclk) begin
    if (ram_en) begin
      en_cnt++;
      ram_rdata <= mem[ram_addr];
      if (ram_we != 4'b0000) begin
        wr_cnt++;
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
      end
    end
  end

  int total = 0;
  int bad = 0;

  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  logic [3:0]  rd_id   [256];
  int          rd_lat  [256];
  int          rd_beats;
  bit          rd_to;
  logic [31:0] wr_data [256];
  logic [3:0]  wr_strb [256];
  bit          wr_to;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;
  logic        b_after;

  task automatic tick;
    @(posedge aclk); #1;
  endtask

  task automatic apply_reset;
    aresetn = 1'b0;
    arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0; rready = 0; bready = 0;
    tick; tick;
    aresetn = 1'b1;
    #1;
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id);
    int cyc;
    int lat;
    rd_to = 0; rd_beats = 0;
    rready = 1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1;
    #1;
    cyc = 0;
    while (!arready && cyc < 50) begin tick; cyc++; end
    if (!arready) begin rd_to = 1; arvalid = 0; return; end
    tick;
    arvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      lat = 1;
      while (!rvalid && lat < 50) begin tick; lat++; end
      if (!rvalid) begin rd_to = 1; return; end
      rd_lat[b] = lat; rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id[b] = rid;
      rd_beats++;
      tick;
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [3:0] id, input int nbeats);
    int cyc;
    wr_to = 0;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1;
    #1;
    cyc = 0;
    while (!awready && cyc < 50) begin tick; cyc++; end
    if (!awready) begin wr_to = 1; awvalid = 0; return; end
    tick;
    awvalid = 0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == nbeats - 1); wvalid = 1;
      #1;
      cyc = 0;
      while (!wready && cyc < 50) begin tick; cyc++; end
      if (!wready) begin wr_to = 1; wvalid = 0; wlast = 0; return; end
      tick;
    end
    wvalid = 0; wlast = 0; bready = 1;
    cyc = 0;
    while (!bvalid && cyc < 50) begin tick; cyc++; end
    if (!bvalid) begin wr_to = 1; bready = 0; return; end
    b_resp = bresp; b_id = bid;
    tick;
    b_after = bvalid;
    bready = 0;
  endtask

  task automatic test_reset;
    apply_reset;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0h exp=0", rvalid); end
    total++; if (bvalid !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%0h exp=0", bvalid); end
    total++; if (wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%0h exp=0", wready); end
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL reset_ram_en got=%0h exp=0", ram_en); end
    total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL reset_ram_we got=%0h exp=0", ram_we); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
    total++; if (rid !== 4'h0) begin bad++; $display("FAIL reset_rid got=%0h exp=0", rid); end
    total++; if (bid !== 4'h0) begin bad++; $display("FAIL reset_bid got=%0h exp=0", bid); end
    total++; if (bresp !== 2'b00) begin bad++; $display("FAIL reset_bresp got=%0h exp=0", bresp); end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL reset_arready got=%0h exp=1", arready); end
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL reset_awready got=%0h exp=1", awready); end
  endtask

  task automatic test_single_read;
    mem[16] = 32'hDEADBEEF;
    read_burst(32'h40, 8'd0, 3'd2, 2'b01, 4'h7);
    total++; if (rd_to !== 1'b0) begin bad++; $display("FAIL single_timeout got=%0d exp=0", rd_to); end
    total++; if (rd_lat[0] != 3) begin bad++; $display("FAIL single_latency got=%0d exp=3", rd_lat[0]); end
    total++; if (rd_data[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%0h exp=deadbeef", rd_data[0]); end
    total++; if (rd_resp[0] !== 2'b00) begin bad++; $display("FAIL single_rresp got=%0h exp=0", rd_resp[0]); end
    total++; if (rd_last[0] !== 1'b1) begin bad++; $display("FAIL single_rlast got=%0h exp=1", rd_last[0]); end
    total++; if (rd_id[0] !== 4'h7) begin bad++; $display("FAIL single_rid got=%0h exp=7", rd_id[0]); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL single_rvalid_drop got=%0h exp=0", rvalid); end
  endtask

  task automatic test_burst_write_read;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) begin wr_data[i] = exp_d[i]; wr_strb[i] = 4'hF; end
    write_burst(32'h100, 8'd3, 3'd2, 2'b01, 4'h3, 4);
    total++; if (wr_to !== 1'b0) begin bad++; $display("FAIL bw_timeout got=%0d exp=0", wr_to); end
    for (int i = 0; i < 4; i++) begin
      total++; if (mem[16'h40 + i] !== exp_d[i]) begin bad++; $display("FAIL bw_mem%0d got=%0h exp=%0h", i, mem[16'h40 + i], exp_d[i]); end
    end
    total++; if (b_resp !== 2'b00) begin bad++; $display("FAIL bw_bresp got=%0h exp=0", b_resp); end
    total++; if (b_id !== 4'h3) begin bad++; $display("FAIL bw_bid got=%0h exp=3", b_id); end
    total++; if (b_after !== 1'b0) begin bad++; $display("FAIL bw_single_b got=%0h exp=0", b_after); end
    read_burst(32'h100, 8'd3, 3'd2, 2'b01, 4'h5);
    total++; if (rd_beats != 4) begin bad++; $display("FAIL br_beats got=%0d exp=4", rd_beats); end
    for (int i = 0; i < 4; i++) begin
      total++; if (rd_data[i] !== exp_d[i]) begin bad++; $display("FAIL br_data%0d got=%0h exp=%0h", i, rd_data[i], exp_d[i]); end
      total++; if (rd_last[i] !== (i == 3)) begin bad++; $display("FAIL br_last%0d got=%0h exp=%0h", i, rd_last[i], (i == 3)); end
      total++; if (rd_lat[i] != 3) begin bad++; $display("FAIL br_lat%0d got=%0d exp=3", i, rd_lat[i]); end
    end
    read_burst(32'h104, 8'd1, 3'd2, 2'b00, 4'h5);
    total++; if (rd_data[1] !== 32'h22) begin bad++; $display("FAIL fixed_beat1 got=%0h exp=22", rd_data[1]); end
  endtask

  task automatic test_strobe;
    mem[16'h200] = 32'h12345678;
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    write_burst(32'h800, 8'd0, 3'd2, 2'b01, 4'h1, 1);
    read_burst(32'h800, 8'd0, 3'd2, 2'b01, 4'h1);
    total++; if (rd_data[0] !== 32'h12BB56DD) begin bad++; $display("FAIL strobe_rdata got=%0h exp=12bb56dd", rd_data[0]); end
  endtask

  task automatic test_arbitration;
    int cyc;
    apply_reset;
    mem[16'h11] = 32'h0;
    araddr = 32'h40; arlen = 0; arsize = 2; arburst = 1; arid = 4'h2;
    awaddr = 32'h44; awlen = 0; awsize = 2; awburst = 1; awid = 4'h4;
    arvalid = 1; awvalid = 1; rready = 1;
    #1;
    total++; if ({arready, awready} !== 2'b10) begin bad++; $display("FAIL arb1_ready got=%0b exp=10", {arready, awready}); end
    tick;
    arvalid = 0; awvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin tick; cyc++; end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL arb1_rdata got=%0h exp=deadbeef", rdata); end
    tick;
    arvalid = 1; awvalid = 1;
    #1;
    total++; if ({arready, awready} !== 2'b01) begin bad++; $display("FAIL arb2_ready got=%0b exp=01", {arready, awready}); end
    tick;
    arvalid = 0; awvalid = 0;
    wdata = 32'h5A5A5A5A; wstrb = 4'hF; wlast = 1; wvalid = 1;
    tick;
    wvalid = 0; wlast = 0; bready = 1;
    cyc = 0;
    while (!bvalid && cyc < 20) begin tick; cyc++; end
    tick;
    bready = 0;
    total++; if (mem[16'h11] !== 32'h5A5A5A5A) begin bad++; $display("FAIL arb2_mem got=%0h exp=5a5a5a5a", mem[16'h11]); end
    arvalid = 1; awvalid = 1;
    #1;
    total++; if ({arready, awready} !== 2'b10) begin bad++; $display("FAIL arb3_ready got=%0b exp=10", {arready, awready}); end
    arvalid = 0; awvalid = 0;
    #1;
  endtask

  task automatic test_errors;
    int snap;
    en_cnt = 0;
    read_burst(32'h40, 8'd0, 3'd3, 2'b01, 4'h2);
    total++; if (rd_resp[0] !== 2'b10) begin bad++; $display("FAIL err_rresp got=%0h exp=2", rd_resp[0]); end
    total++; if (rd_data[0] !== 32'h0) begin bad++; $display("FAIL err_rdata got=%0h exp=0", rd_data[0]); end
    total++; if (en_cnt != 0) begin bad++; $display("FAIL err_ram_en got=%0d exp=0", en_cnt); end
    wr_data[0] = 32'h0; wr_strb[0] = 4'hF;
    write_burst(32'h300, 8'd1, 3'd2, 2'b01, 4'h9, 1);
    total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL early_wlast_bresp got=%0h exp=2", b_resp); end
    total++; if (b_id !== 4'h9) begin bad++; $display("FAIL early_wlast_bid got=%0h exp=9", b_id); end
    snap = wr_cnt;
    wr_data[0] = 32'h1; wr_data[1] = 32'h2;
    wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    write_burst(32'h310, 8'd0, 3'd2, 2'b01, 4'h6, 2);
    total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL late_wlast_bresp got=%0h exp=2", b_resp); end
    total++; if (wr_cnt != snap + 2) begin bad++; $display("FAIL late_wlast_writes got=%0d exp=%0d", wr_cnt, snap + 2); end
    mem[16'hC1] = 32'hCAFEF00D;
    snap = wr_cnt;
    wr_data[0] = 32'hFFFFFFFF;
    write_burst(32'h304, 8'd0, 3'd3, 2'b01, 4'h8, 1);
    total++; if (b_resp !== 2'b10) begin bad++; $display("FAIL wsize_bresp got=%0h exp=2", b_resp); end
    total++; if (wr_cnt != snap) begin bad++; $display("FAIL wsize_writes got=%0d exp=%0d", wr_cnt, snap); end
    total++; if (mem[16'hC1] !== 32'hCAFEF00D) begin bad++; $display("FAIL wsize_mem got=%0h exp=cafef00d", mem[16'hC1]); end
  endtask

  task automatic test_backpressure_reset;
    int cyc;
    int snap;
    bit stable;
    bit quiet;
    logic [31:0] d0;
    mem[16'h20] = 32'h0BADF00D;
    rready = 0; araddr = 32'h80; arlen = 0; arsize = 2; arburst = 1; arid = 4'h1; arvalid = 1;
    #1;
    cyc = 0;
    while (!arready && cyc < 20) begin tick; cyc++; end
    tick;
    arvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin tick; cyc++; end
    d0 = rdata;
    stable = 1;
    repeat (5) begin tick; if (rvalid !== 1'b1 || rdata !== d0) stable = 0; end
    total++; if (d0 !== 32'h0BADF00D) begin bad++; $display("FAIL bp_rdata got=%0h exp=0badf00d", d0); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%0d exp=1", stable); end
    rready = 1;
    tick;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL bp_release got=%0h exp=0", rvalid); end
    rready = 0;
    araddr = 32'hC0; arlen = 3; arvalid = 1;
    #1;
    cyc = 0;
    while (!arready && cyc < 20) begin tick; cyc++; end
    tick;
    arvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin tick; cyc++; end
    aresetn = 0;
    tick;
    aresetn = 1;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rst_rd_rvalid got=%0h exp=0", rvalid); end
    total++; if (arready !== 1'b1) begin bad++; $display("FAIL rst_rd_idle got=%0h exp=1", arready); end
    rready = 1;
    quiet = 1;
    repeat (8) begin tick; if (rvalid !== 1'b0) quiet = 0; end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rst_rd_quiet got=%0d exp=1", quiet); end
    rready = 0;
    mem[16'h102] = 32'h77777777;
    awaddr = 32'h400; awlen = 3; awsize = 2; awburst = 1; awid = 4'hC; awvalid = 1;
    #1;
    cyc = 0;
    while (!awready && cyc < 20) begin tick; cyc++; end
    tick;
    awvalid = 0;
    snap = wr_cnt;
    wstrb = 4'hF; wlast = 0; wvalid = 1; wdata = 32'h1;
    tick;
    wdata = 32'h2;
    tick;
    wdata = 32'hFFFFFFFF;
    aresetn = 0;
    tick;
    aresetn = 1;
    quiet = 1;
    repeat (3) begin tick; if (bvalid !== 1'b0 || wready !== 1'b0) quiet = 0; end
    wvalid = 0;
    total++; if (wr_cnt != snap + 2) begin bad++; $display("FAIL rst_wr_count got=%0d exp=%0d", wr_cnt, snap + 2); end
    total++; if (mem[16'h102] !== 32'h77777777) begin bad++; $display("FAIL rst_wr_mem got=%0h exp=77777777", mem[16'h102]); end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL rst_wr_quiet got=%0d exp=1", quiet); end
  endtask

  task automatic test_long_burst;
    bit lat_ok;
    for (int i = 0; i < 256; i++) mem[16'h1000 + i] = 32'h10000000 + i;
    read_burst(32'h4000, 8'd255, 3'd2, 2'b01, 4'hA);
    total++; if (rd_to !== 1'b0) begin bad++; $display("FAIL long_timeout got=%0d exp=0", rd_to); end
    total++; if (rd_beats != 256) begin bad++; $display("FAIL long_beats got=%0d exp=256", rd_beats); end
    total++; if (rd_data[255] !== 32'h100000FF) begin bad++; $display("FAIL long_last_data got=%0h exp=100000ff", rd_data[255]); end
    total++; if (rd_data[128] !== 32'h10000080) begin bad++; $display("FAIL long_mid_data got=%0h exp=10000080", rd_data[128]); end
    total++; if (rd_last[254] !== 1'b0) begin bad++; $display("FAIL long_rlast254 got=%0h exp=0", rd_last[254]); end
    total++; if (rd_last[255] !== 1'b1) begin bad++; $display("FAIL long_rlast255 got=%0h exp=1", rd_last[255]); end
    lat_ok = 1;
    for (int i = 0; i < 256; i++) if (rd_lat[i] != 3) lat_ok = 0;
    total++; if (lat_ok !== 1'b1) begin bad++; $display("FAIL long_spacing got=%0d exp=1", lat_ok); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL long_end got=%0h exp=0", rvalid); end
  endtask

  initial begin
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; awvalid = 0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
    ram_rdata = 0; b_resp = 0; b_id = 0; b_after = 0;
    test_reset;
    test_single_read;
    test_burst_write_read;
    test_strobe;
    test_arbitration;
    test_errors;
    test_backpressure_reset;
    test_long_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI3 responder (slave) that terminates the cache bridge's AR/R/AW/W/B channels onto a single-port synchronous word SRAM.
- Serves the test/sim memory side of the bridge.
- Handles one transaction at a time.
- Supports single-beat and INCR/FIXED bursts up to 256 beats.

Parameters:
- ADDR_W, 16, SRAM word-address width (depth 2^ADDR_W words, 32-bit words); byte address bits [ADDR_W+1:2] select the word, upper bits ignored.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- arid/araddr/arlen/arsize/arburst/arvalid  in  4/32/8/3/2/1  read address channel
- arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel
- rready  in  1
- awid/awaddr/awlen/awsize/awburst/awvalid  in  4/32/8/3/2/1  write address channel
- awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel (wid ignored)
- wready  out  1
- bid/bresp/bvalid  out  4/2/1  write response channel
- bready  in  1
- ram_en  out  1  SRAM access enable
- ram_we  out  4  byte write enables
- ram_addr  out  ADDR_W  word address
- ram_wdata  out  32  write data
- ram_rdata  in  32  read data, valid one cycle after ram_en with ram_we=0

Behaviour:
- Reset (aresetn=0 at a posedge):
  - state=IDLE, prio_read=1, beat counter=0.
  - rvalid=bvalid=wready=0; ram_en=0, ram_we=0; rdata/rid/bid/bresp=0.
  - Reset mid-transaction abandons it: no further SRAM writes and no R/B beats for it.
- States: IDLE, RD_REQ, RD_CAP, RD_RESP, WR_DATA, WR_RESP.
- IDLE arbitration:
  - arready = IDLE & (!awvalid | prio_read).
  - awready = IDLE & (!arvalid | !prio_read).
  - At most one handshake per cycle.
  - An accepted read clears prio_read; an accepted write sets it.
- ar handshake:
  - Latch id, word address, len, size, burst; beat counter=0.
  - err = (arsize > 3'b010). Go to RD_REQ.
- RD_REQ: ram_en = !err, ram_we=0, ram_addr=current address. Go to RD_CAP.
- RD_CAP: capture ram_rdata into the data register (0 if err). Go to RD_RESP.
- RD_RESP:
  - rvalid=1; rid = latched id; rresp = err ? 2'b10 : 2'b00; rlast = (beat counter == len).
  - rvalid, rdata, rlast stay stable until rready.
  - On r handshake with rlast: go to IDLE.
  - Otherwise: counter+1; address +1 word if burst != 2'b00 (FIXED keeps the address; WRAP is treated as INCR; no 4KB check); go to RD_REQ.
- Read timing:
  - First rvalid is the 3rd cycle after the ar handshake cycle.
  - With rready held high, a new beat arrives every 3 cycles.
- aw handshake:
  - Latch id, address, len, burst; counter=0; err = (awsize > 3'b010). Go to WR_DATA.
- WR_DATA:
  - wready=1.
  - Each w handshake drives the SRAM in the same cycle: ram_en=1, ram_we = err ? 0 : wstrb, ram_wdata=wdata.
  - Then address update (same rule as reads) and counter+1.
  - The handshake with wlast=1 ends the burst; go to WR_RESP.
  - mismatch flag = (wlast arrives with counter != len) or (counter == len without wlast). On the second case the slave keeps accepting beats until wlast.
- WR_RESP:
  - bvalid=1; bid = latched id; bresp = (err | mismatch) ? 2'b10 : 2'b00.
  - Hold until bready; then go to IDLE.
- Outside the states listed above: ram_en=0 and ram_we=0.
- Counter is 8-bit; len=255 gives 256 beats with no overflow.

Optional Feature:
- AXI_SLV_STALL_EN defined:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5 on reset, advances every cycle.
  - While lfsr[0]=1: arready, awready and wready are forced 0, and the RD_CAP->RD_RESP transition is held in RD_CAP (data is re-captured each cycle).
  - rvalid and bvalid are never dropped once asserted.
- Undefined: no stalls; timing exactly as above.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF; AR addr=0x40, len=0, size=2, rready=1 -> rvalid 3 cycles after handshake, rdata=0xDEADBEEF, rresp=0, rlast=1, rid echoed.
- AW addr=0x100, len=3, INCR, W beats 0x11/0x22/0x33/0x44, wstrb=F, wlast on beat 4 -> words 0x40..0x43 written; single B with bresp=0. Then a 4-beat read returns the same data with rlast only on beat 4.
- Write wstrb=4'b0101, wdata=0xAABBCCDD over 0x12345678 -> readback 0x12BB56DD.
- arvalid and awvalid raised in the same cycle from reset -> read accepted first. Next conflict -> write accepted first (alternation).
- arsize=3 -> rresp=2'b10, rdata=0, ram_en never asserted. AW len=1 with wlast on beat 1 -> bresp=2'b10.
- Hold rready=0 for 5 cycles in RD_RESP -> rvalid/rdata stable. Assert aresetn=0 mid-burst -> rvalid=0 next cycle, IDLE, no stray SRAM write.
